// File: rtl/instr_imm_encoder.sv
// Immediate packer for RV32 instruction templates, with a 2-entry result FIFO.
// instr/err are the head FIFO entry. The block also keeps transfer and error counters.
module instr_imm_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  imm_type,
    input  logic [31:0] imm,
    input  logic [31:0] base_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        err,
    output logic [15:0] enc_count,
    output logic [7:0]  err_count
);

    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned ERR_W = 8;
    localparam int unsigned OCC_W = 2;

    localparam logic [2:0] T_I = 3'd0;
    localparam logic [2:0] T_S = 3'd1;
    localparam logic [2:0] T_B = 3'd2;
    localparam logic [2:0] T_U = 3'd3;
    localparam logic [2:0] T_J = 3'd4;

    localparam logic [OCC_W-1:0] OCC_EMPTY = 2'd0;
    localparam logic [OCC_W-1:0] OCC_ONE   = 2'd1;
    localparam logic [OCC_W-1:0] OCC_FULL  = 2'd2;

    logic [W-1:0]     clr_mask;
    logic [W-1:0]     packed_bits;
    logic [W-1:0]     enc_instr;
    logic             enc_err;

    logic [W-1:0]     tail_instr;
    logic             tail_err;
    logic [OCC_W-1:0] occ;

    logic [W-1:0]     head_instr_nxt;
    logic             head_err_nxt;
    logic [W-1:0]     tail_instr_nxt;
    logic             tail_err_nxt;
    logic [OCC_W-1:0] occ_nxt;
    logic             in_ready_nxt;
    logic             out_valid_nxt;
    logic [CNT_W-1:0] enc_count_nxt;
    logic [ERR_W-1:0] err_count_nxt;

    logic             accept;
    logic             pop;

    // Field packing and range check. A reserved type clears nothing and flags an error.
    always_comb begin
        clr_mask    = '0;
        packed_bits = '0;
        enc_err     = 1'b1;
        case (imm_type)
            T_I: begin
                clr_mask    = 32'hFFF0_0000;
                packed_bits = {imm[11:0], 20'd0};
                enc_err     = (imm != {{20{imm[11]}}, imm[11:0]});
            end
            T_S: begin
                clr_mask    = 32'hFE00_0F80;
                packed_bits = {imm[11:5], 13'd0, imm[4:0], 7'd0};
                enc_err     = (imm != {{20{imm[11]}}, imm[11:0]});
            end
            T_B: begin
                clr_mask    = 32'hFE00_0F80;
                packed_bits = {imm[12], imm[10:5], 13'd0, imm[4:1], imm[11], 7'd0};
                enc_err     = imm[0] | (imm != {{19{imm[12]}}, imm[12:0]});
            end
            T_U: begin
                clr_mask    = 32'hFFFF_F000;
                packed_bits = {imm[31:12], 12'd0};
                enc_err     = |imm[11:0];
            end
            T_J: begin
                clr_mask    = 32'hFFFF_F000;
                packed_bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'd0};
                enc_err     = imm[0] | (imm != {{11{imm[20]}}, imm[20:0]});
            end
            default: begin
                clr_mask    = '0;
                packed_bits = '0;
                enc_err     = 1'b1;
            end
        endcase
        enc_instr = (base_instr & ~clr_mask) | packed_bits;
    end

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    // FIFO, handshake and counter next state. Accept and pop together are only possible at occupancy 1.
    always_comb begin
        head_instr_nxt = instr;
        head_err_nxt   = err;
        tail_instr_nxt = tail_instr;
        tail_err_nxt   = tail_err;
        occ_nxt        = occ;
        enc_count_nxt  = enc_count;
        err_count_nxt  = err_count;

        case ({accept, pop})
            2'b10: begin
                if (occ == OCC_EMPTY) begin
                    head_instr_nxt = enc_instr;
                    head_err_nxt   = enc_err;
                end else begin
                    tail_instr_nxt = enc_instr;
                    tail_err_nxt   = enc_err;
                end
                occ_nxt = occ + OCC_ONE;
            end
            2'b01: begin
                head_instr_nxt = tail_instr;
                head_err_nxt   = tail_err;
                occ_nxt        = occ - OCC_ONE;
            end
            2'b11: begin
                head_instr_nxt = enc_instr;
                head_err_nxt   = enc_err;
            end
            default: begin
                occ_nxt = occ;
            end
        endcase

        if (pop) begin
            enc_count_nxt = enc_count + CNT_W'(1);
            if (err && (err_count != {ERR_W{1'b1}})) begin
                err_count_nxt = err_count + ERR_W'(1);
            end
        end

        out_valid_nxt = (occ_nxt != OCC_EMPTY);
        in_ready_nxt  = (occ_nxt != OCC_FULL);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr      <= '0;
            err        <= 1'b0;
            tail_instr <= '0;
            tail_err   <= 1'b0;
            occ        <= OCC_EMPTY;
            out_valid  <= 1'b0;
            in_ready   <= 1'b0;
            enc_count  <= '0;
            err_count  <= '0;
        end else begin
            instr      <= head_instr_nxt;
            err        <= head_err_nxt;
            tail_instr <= tail_instr_nxt;
            tail_err   <= tail_err_nxt;
            occ        <= occ_nxt;
            out_valid  <= out_valid_nxt;
            in_ready   <= in_ready_nxt;
            enc_count  <= enc_count_nxt;
            err_count  <= err_count_nxt;
        end
    end

endmodule

// File: doc/instr_imm_encoder.md
INSTR_IMM_ENCODER -- requirements
Module: instr_imm_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: request present.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-005 SHALL have port imm_type, input, 3 bits: 000 I, 001 S, 010 B, 011 U, 100 J, 101-111 reserved.
REQ-006 SHALL have port imm, input, 32 bits: signed byte-offset/immediate value to pack.
REQ-007 SHALL have port base_instr, input, 32 bits: instruction template carrying opcode/rd/rs1/rs2/funct fields.
REQ-008 SHALL have port out_valid, output, 1 bit: encoded instruction available.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the output.
REQ-010 SHALL have port instr, output, 32 bits: encoded instruction.
REQ-011 SHALL have port err, output, 1 bit: immediate out of range, misaligned, or reserved type; qualified by out_valid.
REQ-012 SHALL have port enc_count, output, 16 bits: number of completed output transfers.
REQ-013 SHALL have port err_count, output, 8 bits: number of completed output transfers with err=1.

Function
REQ-014 SHALL accept a request on a rising edge where in_valid=1 and in_ready=1; SHALL complete an output transfer on a rising edge where out_valid=1 and out_ready=1.
REQ-015 SHALL buffer results in a 2-entry FIFO of {instr, err}, storing the encoded result on acceptance; in_ready SHALL be 1 exactly when occupancy < 2, registered and independent of out_ready.
REQ-016 Latency: a request accepted into an empty FIFO SHALL appear on instr/err with out_valid=1 in the cycle after the accepting edge.
REQ-017 out_valid SHALL be 1 exactly when occupancy > 0; instr/err SHALL show the head entry and hold stable while out_valid=1 and out_ready=0.
REQ-018 Simultaneous accept and transfer SHALL leave occupancy unchanged and preserve FIFO order; at occupancy 2 no accept SHALL occur even if a transfer occurs in the same cycle.
REQ-019 Encoding SHALL first clear the immediate bit positions of base_instr for the selected type, then OR in packed bits:
  - I: instr[31:20]=imm[11:0]
  - S: instr[31:25]=imm[11:5], instr[11:7]=imm[4:0]
  - B: instr[31]=imm[12], instr[7]=imm[11], instr[30:25]=imm[10:5], instr[11:8]=imm[4:1]
  - U: instr[31:12]=imm[31:12]
  - J: instr[31]=imm[20], instr[19:12]=imm[19:12], instr[20]=imm[11], instr[30:21]=imm[10:1]
REQ-020 err SHALL be 1 when:
  - I/S: imm not equal to sign-extension of imm[11:0]
  - B: imm[0]=1 or imm not equal to sign-extension of imm[12:0]
  - U: imm[11:0] not equal to 0
  - J: imm[0]=1 or imm not equal to sign-extension of imm[20:0]
  - reserved type: always 1, with instr = base_instr unchanged
REQ-021 On err, the instruction SHALL still be packed from the truncated imm bits per REQ-019.
REQ-022 enc_count SHALL increment by 1 per output transfer and wrap from 16'hFFFF to 0.
REQ-023 err_count SHALL increment per transfer with err=1 and saturate at 8'hFF.

Reset
REQ-024 While rst_n=0, asynchronously: FIFO emptied, out_valid=0, in_ready=0, instr=0, err=0, enc_count=0, err_count=0.
REQ-025 in_ready SHALL rise in the first cycle after rst_n deasserts; entries in flight at reset assertion SHALL be discarded and never output.

Verification
REQ-026 I-type: base_instr=0x00000013, imm=0xFFFFFFFF, out_ready=1 -> instr=0xFFF00013, err=0, one cycle after acceptance; enc_count=1.
REQ-027 S and U: S with base_instr=0x00002023, imm=0xFFFFFFFC -> instr=0xFE002E23, err=0; U with base_instr=0x00000037, imm=0x12345000 -> instr=0x12345037, err=0.
REQ-028 J and B errors: J with base_instr=0x0000006F, imm=0x00000800 -> instr=0x0010006F, err=0; B with imm=0x00000003 -> err=1, err_count=1; imm_type=111 -> instr=base_instr, err=1.
REQ-029 Backpressure: out_ready=0, offer 3 requests back-to-back -> 2 accepted, in_ready=0 afterwards, head output stable; raise out_ready -> all 3 outputs emerge in order, enc_count=3.
REQ-030 Reset mid-operation: FIFO holding 2 entries, pull rst_n low between edges -> out_valid=0 and counters=0 immediately; after release, no stale entry is output.
